i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have port clk_i, input, 1: system clock; the only clock; frequency at least 4x sclk_i.
REQ-002 SHALL have port rst_n_i, input, 1: reset; asynchronous assert, active-low.
REQ-003 SHALL have port sclk_i, input, 1: I2S bit clock; asynchronous to clk_i.
REQ-004 SHALL have port lrclk_i, input, 1: word select; low = left channel, high = right channel.
REQ-005 SHALL have port sdata_i, input, 1: serial data, MSB first, standard I2S one-bit delay after lrclk_i change.
REQ-006 SHALL have port left_o, output, 16: last complete left sample.
REQ-007 SHALL have port right_o, output, 16: last complete right sample.
REQ-008 SHALL have port valid_o, output, 1: one-clk_i pulse when left_o/right_o update.
REQ-009 SHALL have port frame_err_o, output, 1: sticky framing-error flag (see Configuration).

Function
REQ-010 SHALL pass sclk_i, lrclk_i and sdata_i each through a 2-flop synchronizer on clk_i; no other logic uses the raw pins.
REQ-011 SHALL detect the sclk rising edge as synchronized sclk = 1 while its previous value = 0; all sampling occurs only on that edge-detect cycle.
REQ-012 On each detected edge SHALL sample synchronized lrclk and sdata together.
REQ-013 An edge whose lrclk differs from the previously sampled lrclk SHALL be a channel boundary: its data bit is discarded (LSB of previous word) and bit_cnt (6-bit) clears to 0.
REQ-014 On non-boundary edges with bit_cnt < 16, SHALL shift sdata into the current channel's shift register MSB-first; bit_cnt increments, saturating at 63; bits 17..32 are ignored.
REQ-015 SHALL use states SYNC, LEFT, RIGHT: SYNC -> LEFT on the first lrclk 1->0 boundary after reset; LEFT -> RIGHT on a 0->1 boundary; RIGHT -> LEFT on a 1->0 boundary.
REQ-016 In SYNC SHALL capture nothing and never pulse valid_o.
REQ-017 On RIGHT -> LEFT transition SHALL load left_o and right_o from the shift registers and assert valid_o for exactly one clk_i cycle, in the cycle after the boundary edge is detected.
REQ-018 Pin-to-output latency SHALL be 4 clk_i cycles from the first clk_i edge that sees sclk_i high at the boundary.
REQ-019 A channel receiving fewer than 16 bits before its boundary SHALL deliver its received bits left-justified, zero-padded in the LSBs.
REQ-020 left_o/right_o SHALL hold their value between valid_o pulses.

Reset
REQ-021 On rst_n_i low, SHALL immediately force: state = SYNC, bit_cnt = 0, shift registers = 0, left_o = 0, right_o = 0, valid_o = 0, frame_err_o = 0, synchronizers = 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; after release, the first valid_o occurs only after one full LEFT+RIGHT frame.

Configuration
REQ-023 Macro I2S_RX_FRAME_ERR_EN SHALL gate framing-error checking.
REQ-024 With I2S_RX_FRAME_ERR_EN defined: a boundary leaving LEFT or RIGHT with bit_cnt < 16 SHALL set frame_err_o; it stays set until reset. The frame still completes per REQ-019.
REQ-025 Without I2S_RX_FRAME_ERR_EN defined: frame_err_o SHALL be constant 0; no check logic is synthesized.

Verification
REQ-026 32-bit-per-channel frames, left = 0x1234, right = 0xABCD, clk_i = 8x sclk_i -> one valid_o per frame with left_o = 0x1234 and right_o = 0xABCD; frame_err_o = 0.
REQ-027 First frame entered mid-RIGHT after reset -> no valid_o until the second full frame completes; the second frame's values appear.
REQ-028 16-bit-per-channel frames (exact minimum), left = 0x8001, right = 0x7FFE -> left_o = 0x8001, right_o = 0x7FFE; frame_err_o = 0.
REQ-029 Left channel only 8 bits long (0xA5) -> left_o = 0xA500; frame_err_o = 1 with the macro defined, 0 without it.
REQ-030 rst_n_i pulsed low mid-LEFT -> all outputs go to 0 asynchronously; next valid_o only after a complete subsequent frame.
REQ-031 Continuous frames, values incrementing by 1 -> every valid_o is exactly 1 cycle wide, with no missed or duplicated samples over 100 frames.

Source files
------------

// File: rtl/i2s_receiver.sv
// i2s_receiver: standard I2S slave receiver, oversampled on clk_i.
// sclk_i, lrclk_i and sdata_i are synchronised, sclk rising edges are
// detected, and 16-bit left/right words are captured MSB first. A stereo
// pair is published (valid_o pulse) when the right channel ends.
// Optional feature: define I2S_RX_FRAME_ERR_EN to enable the sticky
// framing-error flag (channel shorter than 16 bits).
module i2s_receiver (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sclk_i,
  input  logic        lrclk_i,
  input  logic        sdata_i,
  output logic [15:0] left_o,
  output logic [15:0] right_o,
  output logic        valid_o,
  output logic        frame_err_o
);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_e;

  localparam logic [5:0] CNT_MAX = 6'd63;
  localparam logic [5:0] CNT_WORD = 6'd16;

  logic [1:0]  sclk_sync_q, lr_sync_q, sd_sync_q;
  logic        sclk_prev_q;
  logic        edge_q;
  logic        lr_smp_q, sd_smp_q;
  logic        sclk_rise;

  logic        lr_last_q, lr_last_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  state_e      state_q, state_d;
  logic [15:0] shift_l_q, shift_l_d;
  logic [15:0] shift_r_q, shift_r_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        valid_q, valid_d;
  logic        boundary;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign boundary  = edge_q && (lr_smp_q != lr_last_q);

  // Two-flop synchronisers, sclk edge detect, and capture of lrclk/sdata
  // on the edge-detect cycle so the FSM sees them one cycle later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      edge_q      <= 1'b0;
      lr_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      lr_sync_q   <= {lr_sync_q[0], lrclk_i};
      sd_sync_q   <= {sd_sync_q[0], sdata_i};
      sclk_prev_q <= sclk_sync_q[1];
      edge_q      <= sclk_rise;
      if (sclk_rise) begin
        lr_smp_q <= lr_sync_q[1];
        sd_smp_q <= sd_sync_q[1];
      end
    end
  end

  // Channel FSM, bit counter, shift registers and output loading.
  always_comb begin
    lr_last_d = lr_last_q;
    bit_cnt_d = bit_cnt_q;
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    if (edge_q) begin
      lr_last_d = lr_smp_q;
      if (boundary) begin
        // Boundary bit is the LSB slot of the previous word: dropped.
        bit_cnt_d = '0;
        case (state_q)
          SYNC: begin
            if (!lr_smp_q) begin
              state_d   = LEFT;
              shift_l_d = '0;
            end
          end
          LEFT: begin
            if (lr_smp_q) begin
              state_d   = RIGHT;
              shift_r_d = '0;
            end
          end
          RIGHT: begin
            if (!lr_smp_q) begin
              state_d   = LEFT;
              left_d    = shift_l_q;
              right_d   = shift_r_q;
              valid_d   = 1'b1;
              shift_l_d = '0;
            end
          end
          default: state_d = SYNC;
        endcase
      end else begin
        // Bits land at position 15-bit_cnt, so short words come out
        // left-justified with zero LSBs (registers cleared at boundary).
        if (bit_cnt_q < CNT_WORD) begin
          if (state_q == LEFT) begin
            shift_l_d[~bit_cnt_q[3:0]] = sd_smp_q;
          end else if (state_q == RIGHT) begin
            shift_r_d[~bit_cnt_q[3:0]] = sd_smp_q;
          end
        end
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lr_last_q <= 1'b0;
      bit_cnt_q <= '0;
      state_q   <= SYNC;
      shift_l_q <= '0;
      shift_r_q <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      lr_last_q <= lr_last_d;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;

`ifdef I2S_RX_FRAME_ERR_EN
  logic err_q, err_d;

  // Sticky flag: any channel closed with fewer than 16 received bits.
  always_comb begin
    err_d = err_q;
    if (boundary && (state_q != SYNC) && (bit_cnt_q < CNT_WORD)) begin
      err_d = 1'b1;
    end
  end

  // Framing-error register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_err_o = err_q;
`else
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Testbench for i2s_receiver: randomized I2S streams, clk = 8x sclk,
// checked against a word-level model of what each frame should deliver.
// A channel of N sclk slots carries its boundary slot plus N-1 data bits.
module tb_i2s_receiver;

`ifdef I2S_RX_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [15:0] left_o, right_o;
  logic        valid_o, frame_err_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_q[$];
  logic        valid_prev = 1'b0;
  int          wide_cnt = 0;

  logic [15:0] fl_val[0:127];
  logic [15:0] fr_val[0:127];
  int          fl_n[0:127];
  int          fr_n[0:127];

  i2s_receiver dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .sclk_i     (sclk),
    .lrclk_i    (lrclk),
    .sdata_i    (sdata),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // Collect every published sample pair and flag pulses wider than 1 cycle.
  always @(negedge clk) begin
    if (valid_o) cap_q.push_back({left_o, right_o});
    if (valid_o && valid_prev) wide_cnt <= wide_cnt + 1;
    valid_prev <= valid_o;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Model: a channel of nslots delivers min(nslots-1,16) bits, left-justified.
  function automatic logic [15:0] exp_word(input logic [15:0] val, input int nslots);
    int nbits;
    nbits = (nslots - 1 > 16) ? 16 : nslots - 1;
    if (nbits >= 16) return val;
    return val & ~(16'hFFFF >> nbits);
  endfunction

  function automatic logic exp_err(input int nfr);
    logic e;
    e = 1'b0;
    for (int i = 0; i < nfr; i++)
      if (fl_n[i] < 17 || fr_n[i] < 17) e = 1'b1;
    return e & ERR_EN;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cap_q.delete();
    wide_cnt = 0;
  endtask

  // One sclk period: data/lrclk change with sclk low, 4 clk low, 4 clk high.
  task automatic send_slot(input logic lr, input logic sd);
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (3) @(negedge clk);
    @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_chan(input logic lr, input logic [15:0] val, input int nslots);
    logic b;
    for (int k = 0; k < nslots; k++) begin
      if (k >= 1 && k <= 16) b = val[16-k];
      else b = 1'($urandom_range(0, 1));
      send_slot(lr, b);
    end
  endtask

  task automatic run_stream(input int nfr, input int pre, input bit flush);
    send_chan(1'b1, 16'($urandom), pre);
    for (int i = 0; i < nfr; i++) begin
      send_chan(1'b0, fl_val[i], fl_n[i]);
      send_chan(1'b1, fr_val[i], fr_n[i]);
    end
    if (flush) begin
      for (int k = 0; k < 3; k++) send_slot(1'b0, 1'($urandom_range(0, 1)));
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (left_o !== 16'h0) begin errors++; $display("FAIL reset_left: got %h want 0000", left_o); end
    checks++; if (right_o !== 16'h0) begin errors++; $display("FAIL reset_right: got %h want 0000", right_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err_o); end
    $display("test_reset done");
  endtask

  task automatic test_basic32();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fl_val[i] = 16'h1234; fl_n[i] = 32;
      fr_val[i] = 16'hABCD; fr_n[i] = 32;
    end
    run_stream(3, 6, 1'b1);
    checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL basic32_count: got %0d want 3", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 3; i++) begin
      checks++;
      if (cap_q[i] !== {16'h1234, 16'hABCD}) begin
        errors++; $display("FAIL basic32_word%0d: got %h want 1234abcd", i, cap_q[i]);
      end
    end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL basic32_err: got %b want 0", frame_err_o); end
    $display("test_basic32: %0d frames received", cap_q.size());
  endtask

  task automatic test_mid_right();
    do_reset();
    fl_val[0] = 16'($urandom); fr_val[0] = 16'($urandom); fl_n[0] = 20; fr_n[0] = 24;
    fl_val[1] = 16'($urandom); fr_val[1] = 16'($urandom); fl_n[1] = 32; fr_n[1] = 18;
    run_stream(2, 23, 1'b1);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL midright_count: got %0d want 2", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 2; i++) begin
      checks++;
      if (cap_q[i] !== {fl_val[i], fr_val[i]}) begin
        errors++; $display("FAIL midright_word%0d: got %h want %h", i, cap_q[i], {fl_val[i], fr_val[i]});
      end
    end
    $display("test_mid_right: %0d frames received", cap_q.size());
  endtask

  task automatic test_min16();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      fl_val[i] = 16'h8001; fl_n[i] = 17;
      fr_val[i] = 16'h7FFE; fr_n[i] = 17;
    end
    run_stream(2, 4, 1'b1);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL min16_count: got %0d want 2", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 2; i++) begin
      checks++;
      if (cap_q[i] !== {16'h8001, 16'h7FFE}) begin
        errors++; $display("FAIL min16_word%0d: got %h want 80017ffe", i, cap_q[i]);
      end
    end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL min16_err: got %b want 0", frame_err_o); end
    $display("test_min16: %0d frames received", cap_q.size());
  endtask

  task automatic test_short_left();
    logic [15:0] el;
    do_reset();
    fl_val[0] = 16'hA500; fl_n[0] = 9;  fr_val[0] = 16'($urandom); fr_n[0] = 20;
    fl_val[1] = 16'($urandom); fl_n[1] = 20; fr_val[1] = 16'($urandom); fr_n[1] = 20;
    run_stream(2, 5, 1'b1);
    el = exp_word(fl_val[0], fl_n[0]);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL short_count: got %0d want 2", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++;
      if (cap_q[0] !== {el, fr_val[0]}) begin
        errors++; $display("FAIL short_word0: got %h want %h", cap_q[0], {el, fr_val[0]});
      end
    end
    checks++;
    if (frame_err_o !== ERR_EN) begin
      errors++; $display("FAIL short_err_sticky: got %b want %b", frame_err_o, ERR_EN);
    end
    $display("test_short_left: left=%h err=%b", left_o, frame_err_o);
  endtask

  task automatic test_async_reset();
    do_reset();
    fl_val[0] = 16'h5A00; fl_n[0] = 9; fr_val[0] = 16'hC3C3; fr_n[0] = 20;
    run_stream(1, 5, 1'b0);
    send_chan(1'b0, 16'h1111, 6);   // boundary publishes frame, now mid-LEFT
    checks++;
    if ({left_o, right_o} !== {16'h5A00, 16'hC3C3}) begin
      errors++; $display("FAIL arst_pre_word: got %h want 5a00c3c3", {left_o, right_o});
    end
    checks++; if (frame_err_o !== ERR_EN) begin errors++; $display("FAIL arst_pre_err: got %b want %b", frame_err_o, ERR_EN); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (left_o !== 16'h0) begin errors++; $display("FAIL arst_left: got %h want 0000", left_o); end
    checks++; if (right_o !== 16'h0) begin errors++; $display("FAIL arst_right: got %h want 0000", right_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", frame_err_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    // Remainder of the interrupted left channel, then a partial right
    // (preamble) which must not publish, then one complete frame.
    for (int k = 0; k < 6; k++) send_slot(1'b0, 1'($urandom_range(0, 1)));
    fl_val[0] = 16'($urandom); fl_n[0] = 20; fr_val[0] = 16'($urandom); fr_n[0] = 20;
    run_stream(1, 12, 1'b1);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL arst_after_count: got %0d want 1", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++;
      if (cap_q[0] !== {fl_val[0], fr_val[0]}) begin
        errors++; $display("FAIL arst_after_word: got %h want %h", cap_q[0], {fl_val[0], fr_val[0]});
      end
    end
    $display("test_async_reset: %0d frames after release", cap_q.size());
  endtask

  task automatic test_random();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fl_val[i] = 16'($urandom); fl_n[i] = $urandom_range(2, 32);
      fr_val[i] = 16'($urandom); fr_n[i] = $urandom_range(2, 32);
    end
    run_stream(10, $urandom_range(2, 12), 1'b1);
    checks++; if (cap_q.size() != 10) begin errors++; $display("FAIL random_count: got %0d want 10", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 10; i++) begin
      exp = {exp_word(fl_val[i], fl_n[i]), exp_word(fr_val[i], fr_n[i])};
      checks++;
      if (cap_q[i] !== exp) begin
        errors++; $display("FAIL random_word%0d: got %h want %h (slots %0d/%0d)", i, cap_q[i], exp, fl_n[i], fr_n[i]);
      end
    end
    checks++;
    if (frame_err_o !== exp_err(10)) begin
      errors++; $display("FAIL random_err: got %b want %b", frame_err_o, exp_err(10));
    end
    $display("test_random: %0d frames, err=%b", cap_q.size(), frame_err_o);
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    do_reset();
    base = 16'($urandom);
    for (int i = 0; i < 100; i++) begin
      fl_val[i] = base + 16'(2 * i);
      fr_val[i] = base + 16'(2 * i + 1);
      fl_n[i] = 17; fr_n[i] = 17;
    end
    run_stream(100, 3, 1'b1);
    checks++; if (cap_q.size() != 100) begin errors++; $display("FAIL b2b_count: got %0d want 100", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 100; i++) begin
      checks++;
      if (cap_q[i] !== {fl_val[i], fr_val[i]}) begin
        errors++; $display("FAIL b2b_word%0d: got %h want %h", i, cap_q[i], {fl_val[i], fr_val[i]});
      end
    end
    checks++; if (wide_cnt != 0) begin errors++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", wide_cnt); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", frame_err_o); end
    $display("test_back_to_back: %0d frames received", cap_q.size());
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    fl_val[0] = 16'($urandom); fl_n[0] = 18; fr_val[0] = 16'($urandom); fr_n[0] = 18;
    run_stream(1, 4, 1'b0);
    @(negedge clk);
    sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    sclk = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (valid_o === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL latency: got %0d cycles want 4 (0 = timeout)", lat); end
    checks++;
    if ({left_o, right_o} !== {fl_val[0], fr_val[0]}) begin
      errors++; $display("FAIL latency_word: got %h want %h", {left_o, right_o}, {fl_val[0], fr_val[0]});
    end
    repeat (4) @(negedge clk);
    $display("test_latency: %0d cycles", lat);
  endtask

  initial begin
    test_reset();
    test_basic32();
    test_mid_right();
    test_min16();
    test_short_left();
    test_async_reset();
    test_random();
    test_back_to_back();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
